// File: rtl/cpu_types_pkg.sv
// Shared CPU type definitions: register index type, writeback source codes
// and the hazard controller state encoding.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  // Writeback source select value meaning "result comes from a load"
  localparam logic [1:0] REGSRC_LOAD = 2'b11;

  typedef enum logic [1:0] {
    RUN,
    LDSTALL,
    MEMWAIT,
    HALTED
  } hz_state_t;

endpackage

// File: rtl/hazard_controller_if.sv
// Port bundle for the hazard controller, same layout as the forwarding unit
// interface: hc is the controller side, tb drives it from a bench or core.
interface hazard_controller_if #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
);
  logic             ihit;
  logic             dhit;
  logic             dREN_me;
  logic             dWEN_me;
  logic [REG_W-1:0] rs_de;
  logic [REG_W-1:0] rt_de;
  logic             usesRt_de;
  logic             jr_de;
  logic             regWr_ex;
  logic [REG_W-1:0] regDst_ex;
  logic [1:0]       regSrc_ex;
  logic             brTaken_ex;
  logic             halt_wb;
  logic             pcEn;
  logic             en_fd;
  logic             en_de;
  logic             en_ex;
  logic             en_me;
  logic             flush_fd;
  logic             flush_de;
  logic             halt;
  logic [CNT_W-1:0] stallCnt;

  modport hc (
    input  ihit, dhit, dREN_me, dWEN_me, rs_de, rt_de, usesRt_de, jr_de,
           regWr_ex, regDst_ex, regSrc_ex, brTaken_ex, halt_wb,
    output pcEn, en_fd, en_de, en_ex, en_me, flush_fd, flush_de, halt, stallCnt
  );

  modport tb (
    output ihit, dhit, dREN_me, dWEN_me, rs_de, rt_de, usesRt_de, jr_de,
           regWr_ex, regDst_ex, regSrc_ex, brTaken_ex, halt_wb,
    input  pcEn, en_fd, en_de, en_ex, en_me, flush_fd, flush_de, halt, stallCnt
  );
endinterface

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: stage enables/flushes for load-use,
// taken branch, memory wait and halt, plus a saturating stall counter.
module hazard_controller
  import cpu_types_pkg::*;
#(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             dREN_me,
  input  logic             dWEN_me,
  input  logic [REG_W-1:0] rs_de,
  input  logic [REG_W-1:0] rt_de,
  input  logic             usesRt_de,
  input  logic             jr_de,
  input  logic             regWr_ex,
  input  logic [REG_W-1:0] regDst_ex,
  input  logic [1:0]       regSrc_ex,
  input  logic             brTaken_ex,
  input  logic             halt_wb,
  output logic             pcEn,
  output logic             en_fd,
  output logic             en_de,
  output logic             en_ex,
  output logic             en_me,
  output logic             flush_fd,
  output logic             flush_de,
  output logic             halt,
  output logic [CNT_W-1:0] stallCnt
);

  hz_state_t        state_q, state_d;
  logic             halt_q, halt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic mem_busy;
  logic rs_hit;
  logic load_use;

  // Hazard terms; JR always reads rs, so jr_de only widens the rs compare
  always_comb begin
    mem_busy = (dREN_me | dWEN_me) & ~dhit;
    rs_hit   = (rs_de == regDst_ex) | (jr_de & (rs_de == regDst_ex));
    load_use = regWr_ex & (regSrc_ex == REGSRC_LOAD) & (regDst_ex != '0) &
               (rs_hit | (usesRt_de & (rt_de == regDst_ex)));
  end

  // Next state and Mealy enables/flushes by fixed priority
  always_comb begin
    state_d  = state_q;
    pcEn     = 1'b0;
    en_fd    = 1'b0;
    en_de    = 1'b0;
    en_ex    = 1'b0;
    en_me    = 1'b0;
    flush_fd = 1'b0;
    flush_de = 1'b0;
    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (mem_busy) begin
      state_d = MEMWAIT;
    end else if (!ihit) begin
      state_d = state_q;
    end else if (brTaken_ex) begin
      {pcEn, en_fd, en_de, en_ex, en_me} = '1;
      flush_fd = 1'b1;
      flush_de = 1'b1;
      state_d  = RUN;
    end else if (load_use) begin
      {en_de, en_ex, en_me} = '1;
      flush_de = 1'b1;
      state_d  = LDSTALL;
    end else begin
      {pcEn, en_fd, en_de, en_ex, en_me} = '1;
      state_d = RUN;
    end
    // HALT already sits in WB, so it overrides any hazard seen this cycle
    if (halt_wb) begin
      state_d = HALTED;
    end
    // Reset holds every stage register frozen
    if (RST) begin
      {pcEn, en_fd, en_de, en_ex, en_me, flush_fd, flush_de} = '0;
    end
  end

  // Sticky halt flag and saturating stall counter
  always_comb begin
    halt_d      = halt_q | halt_wb;
    stall_cnt_d = stall_cnt_q;
    if (!pcEn && !halt_q && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State, halt and counter registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= RUN;
      halt_q      <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      halt_q      <= halt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign halt     = halt_q;
  assign stallCnt = stall_cnt_q;

endmodule
